dm_unit: RTL and testbench

dm_unit is the M-stage data memory of the P6 pipeline and sits directly upstream of DM_ext. It does the following:
- decodes the memory op;
- generates byte enables and replicated store data;
- checks alignment and range;
- performs byte-masked writes;
- registers the raw read word, address and extension mode into the W stage for DM_ext.

It also drives a registered write-log port for the grading testbench.

---
 rtl/dm_pkg.sv | 49 ++++
 rtl/dm_be_gen.sv | 57 +++++
 rtl/dm_unit.sv | 144 ++++++++++++++
 tb/tb_dm_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the M-stage data memory: memory-op codes, DM_ext
// extension modes and the default memory depth.
package dm_pkg;

    localparam int DM_DEPTH = 3072;
    localparam int DM_IDX_W = 12;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LW   = 4'd1,
        MEM_OP_LH   = 4'd2,
        MEM_OP_LHU  = 4'd3,
        MEM_OP_LB   = 4'd4,
        MEM_OP_LBU  = 4'd5,
        MEM_OP_SW   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SB   = 4'd8
    } mem_op_e;

    // Mode codes consumed by DM_ext in the W stage.
    typedef enum logic [2:0] {
        DM_EXT_NONE       = 3'd0,
        DM_EXT_B_UNSIGNED = 3'd1,
        DM_EXT_B_SIGNED   = 3'd2,
        DM_EXT_H_UNSIGNED = 3'd3,
        DM_EXT_H_SIGNED   = 3'd4
    } dm_ext_e;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= MEM_OP_LW) && (op <= MEM_OP_LBU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= MEM_OP_SW) && (op <= MEM_OP_SB);
    endfunction

    function automatic dm_ext_e ext_mode(input logic [3:0] op);
        dm_ext_e mode;
        case (op)
            MEM_OP_LH:  mode = DM_EXT_H_SIGNED;
            MEM_OP_LHU: mode = DM_EXT_H_UNSIGNED;
            MEM_OP_LB:  mode = DM_EXT_B_SIGNED;
            MEM_OP_LBU: mode = DM_EXT_B_UNSIGNED;
            default:    mode = DM_EXT_NONE;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/dm_be_gen.sv
// Combinational store-lane generation and address checking for one memory op:
// byte enables, replicated store data and the load/store address exceptions.
module dm_be_gen
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH
) (
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rep_o,
    output logic        exc_adel_o,
    output logic        exc_ades_o
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    logic out_of_range;
    logic misaligned;

    always_comb begin
        out_of_range = (addr_i >= ADDR_LIMIT);
        misaligned   = 1'b0;
        be_o         = 4'b0000;
        wdata_rep_o  = '0;

        case (mem_op_i)
            MEM_OP_LW, MEM_OP_SW:             misaligned = (addr_i[1:0] != 2'b00);
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: misaligned = addr_i[0];
            default:                          misaligned = 1'b0;
        endcase

        case (mem_op_i)
            MEM_OP_SW: begin
                be_o        = 4'b1111;
                wdata_rep_o = wdata_i;
            end
            MEM_OP_SH: begin
                be_o        = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o = {2{wdata_i[15:0]}};
            end
            MEM_OP_SB: begin
                be_o        = 4'b0001 << addr_i[1:0];
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            default: begin
                be_o        = 4'b0000;
                wdata_rep_o = '0;
            end
        endcase

        exc_adel_o = op_is_load(mem_op_i)  && (misaligned || out_of_range);
        exc_ades_o = op_is_store(mem_op_i) && (misaligned || out_of_range);
    end

endmodule

// File: rtl/dm_unit.sv
// M-stage data memory: byte-masked single-port word array plus the W-side
// registers feeding DM_ext and the registered write-log port.
module dm_unit
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH,
    parameter int IDX_W       = DM_IDX_W
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic [2:0]  ext_mod_o,
    output logic        ld_valid_o,
    output logic        exc_adel_o,
    output logic        exc_ades_o,
    output logic        wr_en_o,
    output logic [31:0] wr_pc_o,
    output logic [31:0] wr_addr_o,
    output logic [3:0]  wr_be_o,
    output logic [31:0] wr_data_o
);

    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic             exc_adel;
    logic             exc_ades;
    logic [IDX_W-1:0] idx;
    logic             do_write;
    logic             ld_ok;

    // Contents survive reset; only power-up starts from zero.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    logic [31:0] rdata_q,    rdata_d;
    logic [31:0] addr_q,     addr_d;
    logic [2:0]  ext_mod_q,  ext_mod_d;
    logic        ld_valid_q, ld_valid_d;
    logic        wr_en_q,    wr_en_d;
    logic [31:0] wr_pc_q,    wr_pc_d;
    logic [31:0] wr_addr_q,  wr_addr_d;
    logic [3:0]  wr_be_q,    wr_be_d;
    logic [31:0] wr_data_q,  wr_data_d;

    dm_be_gen #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_be_gen (
        .mem_op_i    (mem_op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .be_o        (be),
        .wdata_rep_o (wdata_rep),
        .exc_adel_o  (exc_adel),
        .exc_ades_o  (exc_ades)
    );

    assign exc_adel_o = exc_adel;
    assign exc_ades_o = exc_ades;

    assign idx      = addr_i[IDX_W+1:2];
    assign ld_ok    = op_is_load(mem_op_i) && !exc_adel;
    assign do_write = op_is_store(mem_op_i) && !exc_ades && !stall && !flush;

    always_comb begin
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        ext_mod_d  = ext_mod_q;
        ld_valid_d = ld_valid_q;
        wr_en_d    = wr_en_q;
        wr_pc_d    = wr_pc_q;
        wr_addr_d  = wr_addr_q;
        wr_be_d    = wr_be_q;
        wr_data_d  = wr_data_q;

        if (flush) begin
            rdata_d    = '0;
            addr_d     = '0;
            ext_mod_d  = DM_EXT_NONE;
            ld_valid_d = 1'b0;
            wr_en_d    = 1'b0;
        end else if (!stall) begin
            addr_d     = addr_i;
            ext_mod_d  = ext_mode(mem_op_i);
            ld_valid_d = ld_ok;
            rdata_d    = ld_ok ? mem[idx] : '0;
            wr_en_d    = do_write;
            if (do_write) begin
                wr_pc_d   = pc_i;
                wr_addr_d = {addr_i[31:2], 2'b00};
                wr_be_d   = be;
                wr_data_d = wdata_rep;
            end
        end
    end

    // The array shares the reset domain so an edge under reset never writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q    <= '0;
            addr_q     <= '0;
            ext_mod_q  <= DM_EXT_NONE;
            ld_valid_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_pc_q    <= '0;
            wr_addr_q  <= '0;
            wr_be_q    <= '0;
            wr_data_q  <= '0;
        end else begin
            if (do_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                    end
                end
            end
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            ext_mod_q  <= ext_mod_d;
            ld_valid_q <= ld_valid_d;
            wr_en_q    <= wr_en_d;
            wr_pc_q    <= wr_pc_d;
            wr_addr_q  <= wr_addr_d;
            wr_be_q    <= wr_be_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign rdata_o    = rdata_q;
    assign addr_o     = addr_q;
    assign ext_mod_o  = ext_mod_q;
    assign ld_valid_o = ld_valid_q;
    assign wr_en_o    = wr_en_q;
    assign wr_pc_o    = wr_pc_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_be_o    = wr_be_q;
    assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_dm_unit.sv
// Bench for dm_unit: directed scenarios plus randomized traffic against a
// byte-addressed reference memory model.
module tb_dm_unit;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_i = '0;
    logic [3:0]  mem_op_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic [2:0]  ext_mod_o;
    logic        ld_valid_o;
    logic        exc_adel_o;
    logic        exc_ades_o;
    logic        wr_en_o;
    logic [31:0] wr_pc_o;
    logic [31:0] wr_addr_o;
    logic [3:0]  wr_be_o;
    logic [31:0] wr_data_o;

    int total = 0;
    int bad   = 0;

    byte unsigned mem_m [12288];
    logic [31:0] e_rdata, e_addr, e_wr_pc, e_wr_addr, e_wr_data;
    logic [2:0]  e_ext;
    logic        e_ldv, e_wren;
    logic [3:0]  e_wr_be;

    always #5 clk = ~clk;

    dm_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .flush      (flush),
        .pc_i       (pc_i),
        .mem_op_i   (mem_op_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .addr_o     (addr_o),
        .ext_mod_o  (ext_mod_o),
        .ld_valid_o (ld_valid_o),
        .exc_adel_o (exc_adel_o),
        .exc_ades_o (exc_ades_o),
        .wr_en_o    (wr_en_o),
        .wr_pc_o    (wr_pc_o),
        .wr_addr_o  (wr_addr_o),
        .wr_be_o    (wr_be_o),
        .wr_data_o  (wr_data_o)
    );

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd6:       return 4;
            4'd2, 4'd3, 4'd7: return 2;
            4'd4, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic bit m_is_ld(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic bit m_is_st(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic bit m_bad_addr(input logic [3:0] op, input logic [31:0] a);
        int s = op_size(op);
        if (s == 0) return 1'b0;
        return (a >= 32'd12288) || ((a % 32'(s)) != 0);
    endfunction

    function automatic logic [2:0] m_ext(input logic [3:0] op);
        case (op)
            4'd2:    return DM_EXT_H_SIGNED;
            4'd3:    return DM_EXT_H_UNSIGNED;
            4'd4:    return DM_EXT_B_SIGNED;
            4'd5:    return DM_EXT_B_UNSIGNED;
            default: return DM_EXT_NONE;
        endcase
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int base = int'(a & 32'hFFFF_FFFC);
        return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    endfunction

    function automatic void model_reset();
        e_rdata = '0; e_addr = '0; e_ext = '0; e_ldv = 1'b0; e_wren = 1'b0;
        e_wr_pc = '0; e_wr_addr = '0; e_wr_be = '0; e_wr_data = '0;
    endfunction

    // Applies the current inputs at a rising edge.
    function automatic void model_tick();
        int s = op_size(mem_op_i);
        int base;
        logic [3:0]  be;
        logic [31:0] rep;
        bit          bad_a = m_bad_addr(mem_op_i, addr_i);
        if (flush) begin
            e_rdata = '0; e_addr = '0; e_ext = '0; e_ldv = 1'b0; e_wren = 1'b0;
        end else if (!stall) begin
            e_addr  = addr_i;
            e_ext   = m_ext(mem_op_i);
            e_ldv   = m_is_ld(mem_op_i) && !bad_a;
            e_rdata = e_ldv ? m_word(addr_i) : 32'h0;
            e_wren  = m_is_st(mem_op_i) && !bad_a;
            if (e_wren) begin
                base = int'(addr_i);
                be   = '0;
                for (int k = 0; k < s; k++) begin
                    be[(base + k) % 4] = 1'b1;
                    mem_m[base + k]    = wdata_i[8*k +: 8];
                end
                for (int l = 0; l < 4; l++) rep[8*l +: 8] = wdata_i[8*(l % s) +: 8];
                e_wr_pc   = pc_i;
                e_wr_addr = addr_i & 32'hFFFF_FFFC;
                e_wr_be   = be;
                e_wr_data = rep;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic st, input logic fl);
        mem_op_i = op;
        addr_i   = a;
        wdata_i  = d;
        stall    = st;
        flush    = fl;
        pc_i     = $urandom() & 32'hFFFF_FFFC;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({rdata_o, addr_o, ext_mod_o, ld_valid_o, wr_en_o, wr_pc_o, wr_addr_o, wr_be_o, wr_data_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got rdata=%h addr=%h ext=%0d ldv=%b wren=%b wr_pc=%h wr_addr=%h be=%b wd=%h want all zero",
                     rdata_o, addr_o, ext_mod_o, ld_valid_o, wr_en_o, wr_pc_o, wr_addr_o, wr_be_o, wr_data_o);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_store_load();
        set_in(MEM_OP_SW, 32'h10, 32'h1234_5678, 1'b0, 1'b0);
        total++;
        if (exc_ades_o !== 1'b0) begin bad++; $display("FAIL sw_ades got=%b want=0", exc_ades_o); end
        tick();
        total++;
        if ({wr_en_o, wr_be_o, wr_addr_o, wr_data_o} !== {1'b1, 4'b1111, 32'h10, 32'h1234_5678}) begin
            bad++;
            $display("FAIL sw_log got en=%b be=%b addr=%h data=%h want en=1 be=1111 addr=00000010 data=12345678",
                     wr_en_o, wr_be_o, wr_addr_o, wr_data_o);
        end
        total++;
        if (wr_pc_o !== e_wr_pc) begin bad++; $display("FAIL sw_pc got=%h want=%h", wr_pc_o, e_wr_pc); end

        set_in(MEM_OP_LW, 32'h10, 32'h0, 1'b0, 1'b0);
        tick();
        total++;
        if ({rdata_o, ext_mod_o, ld_valid_o, wr_en_o} !== {32'h1234_5678, DM_EXT_NONE, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL lw_read got rdata=%h ext=%0d ldv=%b wren=%b want rdata=12345678 ext=0 ldv=1 wren=0",
                     rdata_o, ext_mod_o, ld_valid_o, wr_en_o);
        end
    endtask

    task automatic test_subword();
        set_in(MEM_OP_SB, 32'h11, 32'h0000_00AB, 1'b0, 1'b0);
        tick();
        total++;
        if ({wr_be_o, wr_data_o} !== {4'b0010, 32'hABAB_ABAB}) begin
            bad++;
            $display("FAIL sb_log got be=%b data=%h want be=0010 data=abababab", wr_be_o, wr_data_o);
        end
        set_in(MEM_OP_LBU, 32'h11, 32'h0, 1'b0, 1'b0);
        tick();
        total++;
        if ({rdata_o, ext_mod_o} !== {32'h1234_AB78, DM_EXT_B_UNSIGNED}) begin
            bad++;
            $display("FAIL lbu_read got rdata=%h ext=%0d want rdata=1234ab78 ext=%0d", rdata_o, ext_mod_o, DM_EXT_B_UNSIGNED);
        end

        set_in(MEM_OP_SH, 32'h12, 32'h0000_BEEF, 1'b0, 1'b0);
        tick();
        total++;
        if ({wr_be_o, wr_data_o} !== {4'b1100, 32'hBEEF_BEEF}) begin
            bad++;
            $display("FAIL sh_log got be=%b data=%h want be=1100 data=beefbeef", wr_be_o, wr_data_o);
        end
        set_in(MEM_OP_LW, 32'h10, 32'h0, 1'b0, 1'b0);
        tick();
        total++;
        if (rdata_o !== 32'hBEEF_AB78) begin bad++; $display("FAIL sh_word got=%h want=beefab78", rdata_o); end

        set_in(MEM_OP_LH, 32'h13, 32'h0, 1'b0, 1'b0);
        total++;
        if ({exc_adel_o, exc_ades_o} !== 2'b10) begin
            bad++;
            $display("FAIL lh_adel got adel=%b ades=%b want adel=1 ades=0", exc_adel_o, exc_ades_o);
        end
        tick();
        total++;
        if (ld_valid_o !== 1'b0) begin bad++; $display("FAIL lh_ldv got=%b want=0", ld_valid_o); end
    endtask

    task automatic test_range();
        set_in(MEM_OP_SW, 32'h2FFC, 32'hCAFE_F00D, 1'b0, 1'b0);
        total++;
        if (exc_ades_o !== 1'b0) begin bad++; $display("FAIL top_word_ades got=%b want=0", exc_ades_o); end
        tick();
        set_in(MEM_OP_SW, 32'h3000, 32'hDEAD_BEEF, 1'b0, 1'b0);
        total++;
        if (exc_ades_o !== 1'b1) begin bad++; $display("FAIL oor_ades got=%b want=1", exc_ades_o); end
        tick();
        total++;
        if ({wr_en_o, wr_addr_o} !== {1'b0, 32'h2FFC}) begin
            bad++;
            $display("FAIL oor_log got en=%b addr=%h want en=0 addr=00002ffc", wr_en_o, wr_addr_o);
        end
        set_in(MEM_OP_LW, 32'h3000, 32'h0, 1'b0, 1'b0);
        total++;
        if (exc_adel_o !== 1'b1) begin bad++; $display("FAIL oor_adel got=%b want=1", exc_adel_o); end
        set_in(MEM_OP_LW, 32'h2FFC, 32'h0, 1'b0, 1'b0);
        tick();
        total++;
        if ({rdata_o, ld_valid_o} !== {32'hCAFE_F00D, 1'b1}) begin
            bad++;
            $display("FAIL top_word_read got rdata=%h ldv=%b want rdata=cafef00d ldv=1", rdata_o, ld_valid_o);
        end
    endtask

    task automatic test_stall_flush();
        set_in(MEM_OP_SW, 32'h20, 32'h55AA_55AA, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if ({wr_en_o, wr_addr_o, addr_o, rdata_o, ld_valid_o} !== {1'b0, 32'h2FFC, 32'h2FFC, 32'hCAFE_F00D, 1'b1}) begin
                bad++;
                $display("FAIL stall_hold%0d got wren=%b wr_addr=%h addr=%h rdata=%h ldv=%b want 0/00002ffc/00002ffc/cafef00d/1",
                         c, wr_en_o, wr_addr_o, addr_o, rdata_o, ld_valid_o);
            end
        end
        set_in(MEM_OP_SW, 32'h20, 32'h55AA_55AA, 1'b0, 1'b0);
        tick();
        total++;
        if ({wr_en_o, wr_addr_o, wr_be_o, wr_data_o} !== {1'b1, 32'h20, 4'b1111, 32'h55AA_55AA}) begin
            bad++;
            $display("FAIL stall_release got en=%b addr=%h be=%b data=%h want 1/00000020/1111/55aa55aa",
                     wr_en_o, wr_addr_o, wr_be_o, wr_data_o);
        end
        set_in(MEM_OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        total++;
        if ({wr_en_o, wr_addr_o} !== {1'b0, 32'h20}) begin
            bad++;
            $display("FAIL one_write got en=%b addr=%h want en=0 addr=00000020", wr_en_o, wr_addr_o);
        end
        set_in(MEM_OP_LB, 32'h20, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(MEM_OP_LW, 32'h20, 32'h0, 1'b1, 1'b1);
        tick();
        total++;
        if ({ld_valid_o, ext_mod_o, rdata_o, addr_o} !== {1'b0, DM_EXT_NONE, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL flush_bubble got ldv=%b ext=%0d rdata=%h addr=%h want all zero",
                     ld_valid_o, ext_mod_o, rdata_o, addr_o);
        end
    endtask

    task automatic test_async_reset();
        set_in(MEM_OP_LW, 32'h10, 32'h0, 1'b0, 1'b0);
        tick();
        total++;
        if (ld_valid_o !== 1'b1) begin bad++; $display("FAIL pre_reset_ldv got=%b want=1", ld_valid_o); end
        set_in(MEM_OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({rdata_o, addr_o, ext_mod_o, ld_valid_o, wr_en_o, wr_pc_o, wr_addr_o, wr_be_o, wr_data_o} !== '0) begin
            bad++;
            $display("FAIL async_clear got rdata=%h addr=%h ldv=%b wr_addr=%h wd=%h want all zero",
                     rdata_o, addr_o, ld_valid_o, wr_addr_o, wr_data_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        set_in(MEM_OP_LW, 32'h10, 32'h0, 1'b0, 1'b0);
        tick();
        total++;
        if (rdata_o !== 32'hBEEF_AB78) begin bad++; $display("FAIL mem_persist got=%h want=beefab78", rdata_o); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        m_adel, m_ades, bad_a;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom();
                1, 2:    a = 32'h2FF0 + $urandom_range(0, 31);
                default: a = $urandom_range(0, 63);
            endcase
            set_in(4'($urandom_range(0, 15)), a, $urandom(),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
            bad_a  = m_bad_addr(mem_op_i, addr_i);
            m_adel = m_is_ld(mem_op_i) && bad_a;
            m_ades = m_is_st(mem_op_i) && bad_a;
            total++;
            if ({exc_adel_o, exc_ades_o} !== {m_adel, m_ades}) begin
                bad++;
                $display("FAIL rnd_exc op=%0d addr=%h got adel=%b ades=%b want adel=%b ades=%b",
                         mem_op_i, addr_i, exc_adel_o, exc_ades_o, m_adel, m_ades);
            end
            tick();
            total++;
            if ({rdata_o, addr_o, ext_mod_o, ld_valid_o} !== {e_rdata, e_addr, e_ext, e_ldv}) begin
                bad++;
                $display("FAIL rnd_wside n=%0d got rdata=%h addr=%h ext=%0d ldv=%b want rdata=%h addr=%h ext=%0d ldv=%b",
                         n, rdata_o, addr_o, ext_mod_o, ld_valid_o, e_rdata, e_addr, e_ext, e_ldv);
            end
            total++;
            if ({wr_en_o, wr_pc_o, wr_addr_o, wr_be_o, wr_data_o} !== {e_wren, e_wr_pc, e_wr_addr, e_wr_be, e_wr_data}) begin
                bad++;
                $display("FAIL rnd_wlog n=%0d got en=%b pc=%h addr=%h be=%b data=%h want en=%b pc=%h addr=%h be=%b data=%h",
                         n, wr_en_o, wr_pc_o, wr_addr_o, wr_be_o, wr_data_o,
                         e_wren, e_wr_pc, e_wr_addr, e_wr_be, e_wr_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_subword();
        test_range();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
